// File: rtl/stack_cpu_pkg.sv
// Shared types for the stack CPU core: opcodes, controller states and fault codes.
package stack_cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OP1,
        S_OP2,
        S_MEM_RD,
        S_MEM_WR,
        S_FAULT
    } state_e;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_UNDER = 2'b01;
    localparam logic [1:0] FAULT_OVER  = 2'b10;

endpackage

// File: rtl/stack_cpu_core_lifo_stack.sv
// Parametrised LIFO: push, pop and in-place top rewrite. Top reads as 0 when empty.
// Push and pop are never requested together by the controller.
module lifo_stack #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic                                 pop_i,
    input  logic                                 wr_top_i,
    input  logic [DATA_W-1:0]                    wdata_i,
    output logic [DATA_W-1:0]                    top_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth_o,
    output logic                                 full_o,
    output logic                                 empty_o
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = $clog2(STACK_DEPTH);

    logic [DEPTH_W-1:0] depth_q;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic [DATA_W-1:0]  entry_rd [STACK_DEPTH];

    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));

    // One register per entry; written on a push into its slot or a rewrite of the top.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : gen_entry
        logic [DATA_W-1:0] entry_q;
        always_ff @(posedge clk) begin
            if ((push_i && push_idx == IDX_W'(gi)) || (wr_top_i && top_idx == IDX_W'(gi))) begin
                entry_q <= wdata_i;
            end
        end
        assign entry_rd[gi] = entry_q;
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push_i) begin
            depth_q <= depth_q + DEPTH_W'(1);
        end else if (pop_i) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end
    end

    assign empty_o = (depth_q == '0);
    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign depth_o = depth_q;
    assign top_o   = empty_o ? '0 : entry_rd[top_idx];

endmodule

// File: rtl/stack_cpu_core.sv
// Multi-cycle stack machine: controller FSM, ALU and LIFO, talking to a unified
// instruction/data memory through a request/ready handshake with wait states.
// Optional trace outputs (trace_pc, trace_ir) exist when STACK_CPU_TRACE_EN is defined.
module stack_cpu_core
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_ready,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_depth,
    output logic [DATA_W-1:0]                  tos,
    output logic                               retire,
    output logic                               fault,
    output logic [1:0]                         fault_code
`ifdef STACK_CPU_TRACE_EN
    ,
    output logic [ADDR_W-1:0]                  trace_pc,
    output logic [DATA_W-1:0]                  trace_ir
`endif
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic               pend_q, pend_d;
    logic               fault_q, fault_d;
    logic [1:0]         code_q, code_d;
    logic               retire_q, retire_d;

    logic               req_c, we_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [DATA_W-1:0]  wdata_c;
    logic               st_push, st_pop, st_wr_top;
    logic [DATA_W-1:0]  st_wdata, st_top;
    logic [DEPTH_W-1:0] st_depth;
    logic               st_full, st_empty, st_ge2;

    opcode_e            opcode;
    logic [ADDR_W-1:0]  operand;
    logic               unused_ir;

    assign opcode    = opcode_e'(ir_q[DATA_W-1 -: 3]);
    assign operand   = ir_q[ADDR_W-1:0];
    assign unused_ir = ^ir_q;
    assign st_ge2    = (st_depth >= DEPTH_W'(2));

    function automatic logic [DATA_W-1:0] alu(input opcode_e op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        case (op)
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            default: alu = a + b;
        endcase
    endfunction

    lifo_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push_i   (st_push),
        .pop_i    (st_pop),
        .wr_top_i (st_wr_top),
        .wdata_i  (st_wdata),
        .top_o    (st_top),
        .depth_o  (st_depth),
        .full_o   (st_full),
        .empty_o  (st_empty)
    );

    // Controller state and architectural registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            pend_q   <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FAULT_NONE;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            pend_q   <= pend_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            retire_q <= retire_d;
        end
    end

    // Next state, memory request and stack commands for the current state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        pend_d    = pend_q;
        fault_d   = fault_q;
        code_d    = code_q;
        retire_d  = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = pc_q;
        wdata_c   = '0;
        st_push   = 1'b0;
        st_pop    = 1'b0;
        st_wr_top = 1'b0;
        st_wdata  = '0;

        case (state_q)
            S_FETCH: begin
                // A request already issued stays up until ready, whatever run does.
                req_c = run || pend_q;
                if (req_c) begin
                    if (mem_ready) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + ADDR_W'(1);
                        pend_d  = 1'b0;
                        state_d = S_DECODE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        if (!st_ge2) begin
                            fault_d = 1'b1;
                            code_d  = FAULT_UNDER;
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_OP1;
                        end
                    end
                    OP_NOT: begin
                        if (st_empty) begin
                            fault_d = 1'b1;
                            code_d  = FAULT_UNDER;
                            state_d = S_FAULT;
                        end else begin
                            st_wr_top = 1'b1;
                            st_wdata  = ~st_top;
                            retire_d  = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    OP_PUSH: begin
                        if (st_full) begin
                            fault_d = 1'b1;
                            code_d  = FAULT_OVER;
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_MEM_RD;
                        end
                    end
                    OP_POP: begin
                        if (st_empty) begin
                            fault_d = 1'b1;
                            code_d  = FAULT_UNDER;
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_MEM_WR;
                        end
                    end
                    OP_JMP: begin
                        pc_d     = operand;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        // JZ: tests the top without popping it.
                        if (st_empty) begin
                            fault_d = 1'b1;
                            code_d  = FAULT_UNDER;
                            state_d = S_FAULT;
                        end else begin
                            if (st_top == '0) begin
                                pc_d = operand;
                            end
                            retire_d = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                endcase
            end
            S_OP1: begin
                // Latch the first operand and expose the second as the new top.
                a_d     = st_top;
                st_pop  = 1'b1;
                state_d = S_OP2;
            end
            S_OP2: begin
                st_wr_top = 1'b1;
                st_wdata  = alu(opcode, a_q, st_top);
                retire_d  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_RD: begin
                req_c  = 1'b1;
                addr_c = operand;
                if (mem_ready) begin
                    st_push  = 1'b1;
                    st_wdata = mem_rdata;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM_WR: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = operand;
                wdata_c = st_top;
                if (mem_ready) begin
                    st_pop   = 1'b1;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign mem_req    = req_c && !rst;
    assign mem_we     = we_c && !rst;
    assign mem_addr   = addr_c;
    assign mem_wdata  = wdata_c;
    assign pc         = pc_q;
    assign sp_depth   = st_depth;
    assign tos        = st_top;
    assign retire     = retire_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

`ifdef STACK_CPU_TRACE_EN
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] trace_pc_q;
    logic [DATA_W-1:0] trace_ir_q;

    // Remember where the current instruction came from; publish it when it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            trace_pc_q <= '0;
            trace_ir_q <= '0;
        end else begin
            if (state_q == S_FETCH && req_c && mem_ready) begin
                fetch_pc_q <= pc_q;
            end
            if (retire_d) begin
                trace_pc_q <= fetch_pc_q;
                trace_ir_q <= ir_q;
            end
        end
    end

    assign trace_pc = trace_pc_q;
    assign trace_ir = trace_ir_q;
`endif

endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: instruction-level reference model plus directed
// literal checks, with a random-wait memory model and random programs.
module tb_stack_cpu_core;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int SD = 4;
    localparam int PW = $clog2(SD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, retire, fault;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata, tos;
    logic [PW-1:0] sp_depth;
    logic [1:0]    fault_code;
`ifdef STACK_CPU_TRACE_EN
    logic [AW-1:0] trace_pc;
    logic [DW-1:0] trace_ir;
`endif

    logic [DW-1:0] bench_mem [32];
    assign mem_rdata = bench_mem[mem_addr];

    stack_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .sp_depth   (sp_depth),
        .tos        (tos),
        .retire     (retire),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef STACK_CPU_TRACE_EN
        ,
        .trace_pc   (trace_pc),
        .trace_ir   (trace_ir)
`endif
    );

    // Reference model state (instruction level).
    logic [7:0] ref_mem [32];
    logic [7:0] ref_stk [$];
    logic [4:0] ref_pc;
    bit         ref_faulted;
    logic [1:0] ref_code;

    int n_checks = 0;
    int n_fail = 0;
    int retire_count = 0;
    int wd = 0;
    bit fault_seen = 1'b0;
    bit prev_req = 1'b0;
    bit prev_ready = 1'b0;
    bit prev_we = 1'b0;
    logic [4:0] prev_addr = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_top();
        if (ref_stk.size() == 0) return 0;
        return int'(ref_stk[ref_stk.size()-1]);
    endfunction

    // Execute one instruction of the ISA; wr_addr reports a memory store (-1 if none).
    task automatic model_step(output int wr_addr);
        logic [7:0] ir, a, b, r;
        logic [2:0] op;
        logic [4:0] opd;
        int n;
        wr_addr = -1;
        ir = ref_mem[ref_pc];
        ref_pc = ref_pc + 5'd1;
        op = ir[7:5];
        opd = ir[4:0];
        n = ref_stk.size();
        case (op)
            3'd0, 3'd1, 3'd2: begin
                if (n < 2) begin ref_faulted = 1'b1; ref_code = 2'b01; end
                else begin
                    a = ref_stk.pop_back();
                    b = ref_stk.pop_back();
                    r = (op == 3'd0) ? a + b : (op == 3'd1) ? a - b : a & b;
                    ref_stk.push_back(r);
                end
            end
            3'd3: begin
                if (n < 1) begin ref_faulted = 1'b1; ref_code = 2'b01; end
                else ref_stk[n-1] = ~ref_stk[n-1];
            end
            3'd4: begin
                if (n == SD) begin ref_faulted = 1'b1; ref_code = 2'b10; end
                else ref_stk.push_back(ref_mem[opd]);
            end
            3'd5: begin
                if (n == 0) begin ref_faulted = 1'b1; ref_code = 2'b01; end
                else begin ref_mem[opd] = ref_stk.pop_back(); wr_addr = int'(opd); end
            end
            3'd6: ref_pc = opd;
            default: begin
                if (n == 0) begin ref_faulted = 1'b1; ref_code = 2'b01; end
                else if (ref_stk[n-1] == 8'd0) ref_pc = opd;
            end
        endcase
    endtask

    // Registered outputs, checked against the model on every retire or fault event.
    task automatic check_regs();
        int w;
        if (rst) begin
            chk("reset pc", int'(pc), 0);
            chk("reset depth", int'(sp_depth), 0);
            chk("reset tos", int'(tos), 0);
            chk("reset fault", int'(fault), 0);
            chk("reset code", int'(fault_code), 0);
            chk("reset retire", int'(retire), 0);
            ref_pc = '0;
            ref_stk.delete();
            ref_faulted = 1'b0;
            ref_code = 2'b00;
            fault_seen = 1'b0;
            wd = 0;
        end else begin
            if (retire) begin
                retire_count++;
                wd = 0;
                chk("retire while faulted", int'(fault), 0);
                model_step(w);
                chk("retired faulting instr", int'(ref_faulted), 0);
                chk("pc after retire", int'(pc), int'(ref_pc));
                chk("depth after retire", int'(sp_depth), ref_stk.size());
                chk("tos after retire", int'(tos), ref_top());
                if (w >= 0) chk("stored word", int'(bench_mem[w]), int'(ref_mem[w]));
            end else if (fault && !fault_seen) begin
                fault_seen = 1'b1;
                wd = 0;
                if (!ref_faulted) model_step(w);
                chk("fault predicted", int'(ref_faulted), 1);
                chk("fault code", int'(fault_code), int'(ref_code));
                chk("pc at fault", int'(pc), int'(ref_pc));
                chk("depth at fault", int'(sp_depth), ref_stk.size());
            end else if (!ref_faulted) begin
                wd++;
                if (wd > 100) begin
                    chk("watchdog no retire", wd, 0);
                    wd = 0;
                end
            end
            if (fault_seen) begin
                chk("fault sticky", int'(fault), 1);
                chk("retire after fault", int'(retire), 0);
            end
        end
    endtask

    // Combinational memory-side checks and the memory store itself.
    task automatic check_comb();
        if (rst) begin
            chk("req under rst", int'(mem_req), 0);
            chk("we under rst", int'(mem_we), 0);
        end else begin
            if (prev_req && !prev_ready) begin
                chk("req held", int'(mem_req), 1);
                chk("addr held", int'(mem_addr), int'(prev_addr));
                chk("we held", int'(mem_we), int'(prev_we));
            end
            if (fault_seen) chk("req in fault", int'(mem_req), 0);
        end
        if (mem_req && mem_we && mem_ready) bench_mem[mem_addr] = mem_wdata;
        prev_req = mem_req;
        prev_ready = mem_ready;
        prev_we = mem_we;
        prev_addr = mem_addr;
    endtask

    task automatic step(input bit r, input bit rn, input bit rdy);
        @(negedge clk);
        #1;
        check_regs();
        rst = r;
        run = rn;
        mem_ready = rdy;
        #1;
        check_comb();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        retire_count = 0;
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] v);
        bench_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) load(5'(i), 8'h00);
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (retire_count < n && k < budget) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        if (retire_count < n) chk("retire timeout", retire_count, n);
    endtask

    initial begin
        int fourth, first_fault;
        logic [2:0] op;
        clear_mem();

        // PUSH 20, PUSH 21, ADD, POP 22 with zero waits.
        do_reset();
        clear_mem();
        load(5'd0, 8'h94); load(5'd1, 8'h95); load(5'd2, 8'h00); load(5'd3, 8'hB6);
        load(5'd4, 8'hC4); load(5'd20, 8'd3); load(5'd21, 8'd5);
        fourth = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (retire_count == 4 && fourth == 0) fourth = i;
        end
        // 13 execution cycles; the 4th retire pulse appears in the cycle after.
        chk("tp1 4th retire step", fourth, 14);
        chk("tp1 mem22", int'(bench_mem[22]), 8);
        chk("tp1 model mem22", int'(ref_mem[22]), 8);
        chk("tp1 depth", int'(sp_depth), 0);

        // SUB: 4 - 9 = 251.
        do_reset();
        clear_mem();
        load(5'd0, 8'h94); load(5'd1, 8'h95); load(5'd2, 8'h20); load(5'd3, 8'hC3);
        load(5'd20, 8'd9); load(5'd21, 8'd4);
        run_until(3, 40);
        chk("sub tos", int'(tos), 251);
        chk("sub depth", int'(sp_depth), 1);

        // Fetch with 3 wait cycles, run dropped while waiting.
        do_reset();
        clear_mem();
        load(5'd0, 8'hC5); load(5'd5, 8'hC5);
        step(1'b0, 1'b1, 1'b0);
        chk("wait req c1", int'(mem_req), 1); chk("wait addr c1", int'(mem_addr), 0);
        for (int i = 2; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("wait req", int'(mem_req), 1); chk("wait addr", int'(mem_addr), 0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("wait req c4", int'(mem_req), 1); chk("wait addr c4", int'(mem_addr), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("wait pc once", int'(pc), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("jmp pc", int'(pc), 5);
        chk("idle req", int'(mem_req), 0);

        // Overflow on the 5th PUSH with depth 4.
        do_reset();
        clear_mem();
        for (int i = 0; i < 5; i++) load(5'(i), 8'h8A);
        load(5'd10, 8'h77);
        first_fault = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (fault && first_fault == 0) first_fault = i;
        end
        chk("ovf step", first_fault, 15);
        chk("ovf fault", int'(fault), 1);
        chk("ovf code", int'(fault_code), 2);
        chk("ovf depth", int'(sp_depth), 4);
        chk("ovf req", int'(mem_req), 0);

        // ADD on empty stack -> underflow.
        do_reset();
        clear_mem();
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1);
        chk("unf fault", int'(fault), 1);
        chk("unf code", int'(fault_code), 1);
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("rst clears fault", int'(fault), 0);
        chk("rst clears code", int'(fault_code), 0);

        // JZ taken / not taken, and pc wrap.
        do_reset();
        clear_mem();
        load(5'd0, 8'h94); load(5'd1, 8'hE7); load(5'd7, 8'hC7); load(5'd20, 8'd0);
        run_until(2, 30);
        chk("jz taken pc", int'(pc), 7);
        chk("jz taken depth", int'(sp_depth), 1);
        do_reset();
        clear_mem();
        load(5'd0, 8'h94); load(5'd1, 8'hE7); load(5'd2, 8'hC2); load(5'd20, 8'd1);
        run_until(2, 30);
        chk("jz fall pc", int'(pc), 2);
        chk("jz fall depth", int'(sp_depth), 1);
        do_reset();
        clear_mem();
        load(5'd0, 8'hDF); load(5'd31, 8'h94); load(5'd20, 8'h33);
        run_until(2, 30);
        chk("wrap pc", int'(pc), 0);
        chk("wrap tos", int'(tos), 51);

        // Reset during a stalled MEM_RD.
        do_reset();
        clear_mem();
        load(5'd0, 8'h94); load(5'd20, 8'd5);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("memrd req", int'(mem_req), 1);
        chk("memrd we", int'(mem_we), 0);
        chk("memrd addr", int'(mem_addr), 20);
        step(1'b1, 1'b1, 1'b0);
        chk("abandon req", int'(mem_req), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("abandon pc", int'(pc), 0);
        chk("abandon depth", int'(sp_depth), 0);
        chk("abandon fault", int'(fault), 0);

        // Random programs with random waits, run gaps and occasional resets.
        for (int p = 0; p < 30; p++) begin
            do_reset();
            for (int a = 0; a < 32; a++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: op = 3'd4;
                    4, 7:       op = 3'd5;
                    5:          op = 3'd0;
                    6:          op = 3'($urandom_range(1, 3));
                    8:          op = 3'd6;
                    default:    op = 3'd7;
                endcase
                load(5'(a), {op, 5'($urandom_range(0, 31))});
            end
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 1'b0);
                else step(1'b0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
